// File: rtl/mux_3x1_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mux_3x1_bus_arbiter
//
// Purpose:
//   Shares one WIDTH-bit output channel between three requesters (A=0, B=1,
//   C=2). An owner is chosen in IDLE, locked for a whole burst (ending on an
//   accepted beat with last, or forcibly after MAX_BURST beats), and its beats
//   pass through one output register with valid/ready back-pressure.
//
// Configuration:
//   ARB_FIXED_PRIORITY_EN - when defined, IDLE selection is fixed priority
//                           A > B > C and the round-robin pointer is frozen.
//                           Undefined (default): round-robin arbitration.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_{a,b,c}_valid / _last / _data requester beat, burst end, payload
//   o_{a,b,c}_ready                 beat accepted when valid && ready
//   o_out_valid, i_out_ready        output handshake
//   o_out_data, o_out_sel, o_out_last  registered payload, owner index, last
//   o_grant                         one-hot current owner (bit0 = A)
//   o_burst_err                     one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module mux_3x1_bus_arbiter #(
  parameter int WIDTH     = 64,
  parameter int MAX_BURST = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_a_valid,
  input  logic             i_b_valid,
  input  logic             i_c_valid,
  input  logic             i_a_last,
  input  logic             i_b_last,
  input  logic             i_c_last,
  input  logic [WIDTH-1:0] i_a_data,
  input  logic [WIDTH-1:0] i_b_data,
  input  logic [WIDTH-1:0] i_c_data,
  output logic             o_a_ready,
  output logic             o_b_ready,
  output logic             o_c_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_out_sel,
  output logic             o_out_last,
  output logic [2:0]       o_grant,
  output logic             o_burst_err
);

  localparam int CNTW = $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MAX_BURST - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           r_state, w_state_next;
  logic [2:0]       r_grant, w_grant_next;
  logic [1:0]       r_rr_ptr, w_rr_next;
  logic [CNTW-1:0]  r_cnt, w_cnt_next;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_sel;
  logic             r_out_last;
  logic             r_burst_err;

  logic [2:0]       w_valid;
  logic [2:0]       w_pick;
  logic [1:0]       w_own_idx;
  logic             w_own_valid;
  logic             w_own_last;
  logic [WIDTH-1:0] w_own_data;
  logic             w_can_load;
  logic             w_accept;
  logic             w_max_beat;
  logic             w_burst_end;
  logic             w_forced;

  assign w_valid = {i_c_valid, i_b_valid, i_a_valid};

  // The output register can take a new beat when it is empty or draining.
  assign w_can_load = !r_out_valid || i_out_ready;

  // Owner index and its beat; with no grant the index defaults to A but
  // w_own_valid is 0, so nothing can be accepted.
  always_comb begin
    w_own_idx  = 2'd0;
    w_own_last = i_a_last;
    w_own_data = i_a_data;
    if (r_grant[1]) begin
      w_own_idx  = 2'd1;
      w_own_last = i_b_last;
      w_own_data = i_b_data;
    end else if (r_grant[2]) begin
      w_own_idx  = 2'd2;
      w_own_last = i_c_last;
      w_own_data = i_c_data;
    end
  end

  assign w_own_valid = |(r_grant & w_valid);
  assign w_accept    = (r_state == LOCKED) && w_own_valid && w_can_load;
  assign w_max_beat  = (r_cnt == LAST_CNT);
  assign w_burst_end = w_accept && (w_own_last || w_max_beat);
  assign w_forced    = w_accept && !w_own_last && w_max_beat;

  assign o_a_ready = (r_state == LOCKED) && r_grant[0] && w_can_load;
  assign o_b_ready = (r_state == LOCKED) && r_grant[1] && w_can_load;
  assign o_c_ready = (r_state == LOCKED) && r_grant[2] && w_can_load;

  // IDLE selection: search starts one past the last owner so each requester
  // gets a turn; the fixed-priority build always prefers A, then B, then C.
  always_comb begin
    w_pick = 3'b000;
`ifdef ARB_FIXED_PRIORITY_EN
    if      (w_valid[0]) w_pick = 3'b001;
    else if (w_valid[1]) w_pick = 3'b010;
    else if (w_valid[2]) w_pick = 3'b100;
`else
    case (r_rr_ptr)
      2'd0: begin
        if      (w_valid[1]) w_pick = 3'b010;
        else if (w_valid[2]) w_pick = 3'b100;
        else if (w_valid[0]) w_pick = 3'b001;
      end
      2'd1: begin
        if      (w_valid[2]) w_pick = 3'b100;
        else if (w_valid[0]) w_pick = 3'b001;
        else if (w_valid[1]) w_pick = 3'b010;
      end
      default: begin
        if      (w_valid[0]) w_pick = 3'b001;
        else if (w_valid[1]) w_pick = 3'b010;
        else if (w_valid[2]) w_pick = 3'b100;
      end
    endcase
`endif
  end

  // Next-state logic: grant on any request in IDLE, release on burst end.
  // The counter stops at MAX_BURST at most because that beat always releases.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_rr_next    = r_rr_ptr;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (|w_pick) begin
          w_state_next = LOCKED;
          w_grant_next = w_pick;
          w_cnt_next   = '0;
        end
      end
      LOCKED: begin
        if (w_accept) begin
          w_cnt_next = r_cnt + CNTW'(1);
        end
        if (w_burst_end) begin
          w_state_next = IDLE;
          w_grant_next = 3'b000;
`ifndef ARB_FIXED_PRIORITY_EN
          w_rr_next    = w_own_idx;
`endif
        end
      end
      default: begin
        w_state_next = IDLE;
        w_grant_next = 3'b000;
      end
    endcase
  end

  // FSM and arbitration state registers; pointer resets to C so A wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_grant  <= 3'b000;
      r_rr_ptr <= 2'd2;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_rr_ptr <= w_rr_next;
      r_cnt    <= w_cnt_next;
    end
  end

  // Output stage: load on accept (even while draining, so no bubble), empty
  // on drain without a new beat, otherwise hold. A forced release marks the
  // beat as last so downstream sees a closed burst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 2'd0;
      r_out_last  <= 1'b0;
      r_burst_err <= 1'b0;
    end else begin
      r_burst_err <= w_forced;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_own_data;
        r_out_sel   <= w_own_idx;
        r_out_last  <= w_own_last || w_max_beat;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_sel   = r_out_sel;
  assign o_out_last  = r_out_last;
  assign o_grant     = r_grant;
  assign o_burst_err = r_burst_err;

endmodule

// File: tb/tb_mux_3x1_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_3x1_bus_arbiter
//
// Directed bench for mux_3x1_bus_arbiter (default round-robin build,
// MAX_BURST=16). Inputs change and outputs are sampled 1 time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_mux_3x1_bus_arbiter;

  localparam int WIDTH = 64;

  logic             clk;
  logic             rst_n;
  logic             aValid, bValid, cValid;
  logic             aLast, bLast, cLast;
  logic [WIDTH-1:0] aData, bData, cData;
  logic             aReady, bReady, cReady;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData;
  logic [1:0]       outSel;
  logic             outLast;
  logic [2:0]       grant;
  logic             burstErr;

  int total = 0;
  int bad   = 0;

  mux_3x1_bus_arbiter #(.WIDTH(WIDTH), .MAX_BURST(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a_valid   (aValid),
    .i_b_valid   (bValid),
    .i_c_valid   (cValid),
    .i_a_last    (aLast),
    .i_b_last    (bLast),
    .i_c_last    (cLast),
    .i_a_data    (aData),
    .i_b_data    (bData),
    .i_c_data    (cData),
    .o_a_ready   (aReady),
    .o_b_ready   (bReady),
    .o_c_ready   (cReady),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_data  (outData),
    .o_out_sel   (outSel),
    .o_out_last  (outLast),
    .o_grant     (grant),
    .o_burst_err (burstErr)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every requester and the output port to an idle pattern.
  task automatic applyStimulus();
    aValid = 0; bValid = 0; cValid = 0;
    aLast = 0; bLast = 0; cLast = 0;
    aData = '0; bData = '0; cData = '0;
    outReady = 1;
  endtask

  // Pulse reset for one edge and release it away from the edge.
  task automatic do_reset();
    applyStimulus();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    applyStimulus();
    rst_n = 0;
    #2;
    total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0h exp=0", outValid); end
    total++; if (outData !== 64'd0) begin bad++; $display("[TB] FAIL reset_data got=%0h exp=0", outData); end
    total++; if (outSel !== 2'd0) begin bad++; $display("[TB] FAIL reset_sel got=%0h exp=0", outSel); end
    total++; if (outLast !== 1'b0) begin bad++; $display("[TB] FAIL reset_last got=%0h exp=0", outLast); end
    total++; if (grant !== 3'b000) begin bad++; $display("[TB] FAIL reset_grant got=%0h exp=0", grant); end
    total++; if (burstErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%0h exp=0", burstErr); end
    total++; if ({cReady, bReady, aReady} !== 3'b000) begin bad++; $display("[TB] FAIL reset_ready got=%0h exp=0", {cReady, bReady, aReady}); end
    tick();
    rst_n = 1;
  endtask

  task automatic test_single_a();
    do_reset();
    aValid = 1; aLast = 1; aData = 64'd11; outReady = 1;
    tick();
    total++; if (grant !== 3'b001) begin bad++; $display("[TB] FAIL single_grant got=%0h exp=1", grant); end
    total++; if (aReady !== 1'b1) begin bad++; $display("[TB] FAIL single_aready got=%0h exp=1", aReady); end
    tick();
    aValid = 0;
    total++; if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%0h exp=1", outValid); end
    total++; if (outData !== 64'd11) begin bad++; $display("[TB] FAIL single_data got=%0h exp=b", outData); end
    total++; if (outSel !== 2'd0) begin bad++; $display("[TB] FAIL single_sel got=%0h exp=0", outSel); end
    total++; if (outLast !== 1'b1) begin bad++; $display("[TB] FAIL single_last got=%0h exp=1", outLast); end
    total++; if (grant !== 3'b000) begin bad++; $display("[TB] FAIL single_release got=%0h exp=0", grant); end
    tick();
    total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL single_drain got=%0h exp=0", outValid); end
  endtask

  task automatic test_round_robin();
    logic [2:0]       expGrant [4];
    logic [WIDTH-1:0] expData [4];
    logic [1:0]       expSel [4];
    expGrant = '{3'b001, 3'b010, 3'b100, 3'b001};
    expData  = '{64'd11, 64'd22, 64'd33, 64'd11};
    expSel   = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    aValid = 1; bValid = 1; cValid = 1;
    aLast = 1; bLast = 1; cLast = 1;
    aData = 64'd11; bData = 64'd22; cData = 64'd33;
    outReady = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (grant !== expGrant[i]) begin bad++; $display("[TB] FAIL rr_grant%0d got=%0h exp=%0h", i, grant, expGrant[i]); end
      tick();
      total++; if (outValid !== 1'b1 || outData !== expData[i] || outSel !== expSel[i]) begin
        bad++; $display("[TB] FAIL rr_out%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, outValid, outData, outSel, expData[i], expSel[i]);
      end
      total++; if (grant !== 3'b000) begin bad++; $display("[TB] FAIL rr_idle%0d got=%0h exp=0", i, grant); end
    end
    applyStimulus();
  endtask

  task automatic test_burst_b();
    logic [WIDTH-1:0] beats [3];
    beats = '{64'd22, 64'd23, 64'd24};
    do_reset();
    bValid = 1; bLast = 0; bData = beats[0]; outReady = 1;
    tick();
    aValid = 1; aLast = 1; aData = 64'd11;
    cValid = 1; cLast = 1; cData = 64'd33;
    for (int i = 0; i < 3; i++) begin
      total++; if (grant !== 3'b010 || {cReady, bReady, aReady} !== 3'b010) begin
        bad++; $display("[TB] FAIL burst_lock%0d got=%0h/%0h exp=2/2", i, grant, {cReady, bReady, aReady});
      end
      tick();
      total++; if (outData !== beats[i] || outSel !== 2'd1 || outLast !== (i == 2)) begin
        bad++; $display("[TB] FAIL burst_beat%0d got=%0h/%0h/%0h exp=%0h/1/%0h", i, outData, outSel, outLast, beats[i], (i == 2));
      end
      if (i < 2) begin
        bData = beats[i + 1];
        bLast = (i == 1);
      end
    end
    bValid = 0;
    total++; if (grant !== 3'b000) begin bad++; $display("[TB] FAIL burst_release got=%0h exp=0", grant); end
    tick();
    total++; if (grant !== 3'b100) begin bad++; $display("[TB] FAIL burst_next got=%0h exp=4", grant); end
    applyStimulus();
  endtask

  task automatic test_back_pressure();
    do_reset();
    cValid = 1; cLast = 0; cData = 64'd33; outReady = 0;
    tick();
    total++; if (grant !== 3'b100 || cReady !== 1'b1) begin bad++; $display("[TB] FAIL bp_grant got=%0h/%0h exp=4/1", grant, cReady); end
    tick();
    cData = 64'd34;
    total++; if (cReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_stall got=%0h exp=0", cReady); end
    total++; if (outValid !== 1'b1 || outData !== 64'd33) begin bad++; $display("[TB] FAIL bp_first got=%0h/%0h exp=1/21", outValid, outData); end
    tick();
    total++; if (outValid !== 1'b1 || outData !== 64'd33 || outSel !== 2'd2) begin
      bad++; $display("[TB] FAIL bp_hold got=%0h/%0h/%0h exp=1/21/2", outValid, outData, outSel);
    end
    outReady = 1;
    #1;
    total++; if (cReady !== 1'b1) begin bad++; $display("[TB] FAIL bp_resume_ready got=%0h exp=1", cReady); end
    tick();
    cData = 64'd35; cLast = 1;
    total++; if (outValid !== 1'b1 || outData !== 64'd34) begin bad++; $display("[TB] FAIL bp_reload got=%0h/%0h exp=1/22", outValid, outData); end
    tick();
    cValid = 0;
    total++; if (outData !== 64'd35 || outLast !== 1'b1 || grant !== 3'b000) begin
      bad++; $display("[TB] FAIL bp_end got=%0h/%0h/%0h exp=23/1/0", outData, outLast, grant);
    end
    applyStimulus();
  endtask

  task automatic test_forced_release();
    do_reset();
    aValid = 1; aLast = 0; aData = 64'd100;
    bValid = 1; bLast = 1; bData = 64'd22;
    outReady = 1;
    tick();
    total++; if (grant !== 3'b001) begin bad++; $display("[TB] FAIL force_grant got=%0h exp=1", grant); end
    for (int i = 0; i < 16; i++) begin
      tick();
      aData = 64'(100 + i + 1);
      total++; if (outData !== 64'(100 + i) || outLast !== (i == 15) || burstErr !== (i == 15)) begin
        bad++; $display("[TB] FAIL force_beat%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, outData, outLast, burstErr, 100 + i, (i == 15), (i == 15));
      end
    end
    total++; if (grant !== 3'b000) begin bad++; $display("[TB] FAIL force_release got=%0h exp=0", grant); end
    tick();
    total++; if (burstErr !== 1'b0) begin bad++; $display("[TB] FAIL force_pulse got=%0h exp=0", burstErr); end
    total++; if (grant !== 3'b010) begin bad++; $display("[TB] FAIL force_next got=%0h exp=2", grant); end
    applyStimulus();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    aValid = 1; aLast = 0; aData = 64'd50; outReady = 1;
    tick();
    tick();
    aData = 64'd51;
    tick();
    aData = 64'd52;
    total++; if (outData !== 64'd51 || outValid !== 1'b1) begin bad++; $display("[TB] FAIL mid_beat2 got=%0h/%0h exp=33/1", outData, outValid); end
    rst_n = 0;
    #1;
    total++; if (outValid !== 1'b0 || grant !== 3'b000 || aReady !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_reset got=%0h/%0h/%0h exp=0/0/0", outValid, grant, aReady);
    end
    total++; if (outData !== 64'd0) begin bad++; $display("[TB] FAIL mid_reset_data got=%0h exp=0", outData); end
    #1;
    rst_n = 1;
    bValid = 1; bLast = 1; cValid = 1; cLast = 1;
    tick();
    total++; if (grant !== 3'b001) begin bad++; $display("[TB] FAIL mid_rewin got=%0h exp=1", grant); end
    applyStimulus();
  endtask

  initial begin
    rst_n = 1;
    applyStimulus();
    #1;
    test_reset();
    test_single_a();
    test_round_robin();
    test_burst_b();
    test_back_pressure();
    test_forced_release();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_3x1_bus_arbiter.md
Name: mux_3x1_bus_arbiter

Overview:
- Round-robin arbiter that shares one 64-bit output channel between three requesters (A=0, B=1, C=2).
- Sequences the select of the 3:1 64-bit data mux. Drives the registered select alongside its output.
- Locks the grant for a whole burst, ending at the beat with `last`. Adds one output register stage with valid/ready back-pressure.
- Sits between producer stages (fetch, load/store, writeback) and a shared downstream port.

Parameters:
- WIDTH, 64: data width of each requester and of the output.
- MAX_BURST, 16: maximum beats per locked burst before a forced release.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a_valid, b_valid, c_valid  in  1 each  requester beat valid
- a_last, b_last, c_last  in  1 each  final beat of burst, qualified by valid
- a_data, b_data, c_data  in  WIDTH each  requester payload
- a_ready, b_ready, c_ready  out  1 each  beat accepted when valid&&ready
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  WIDTH  registered muxed payload
- out_sel  out  2  requester index of out_data (0=A, 1=B, 2=C)
- out_last  out  1  registered last flag
- grant  out  3  one-hot current owner, bit0=A
- burst_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: out_valid=0, out_data=0, out_sel=0, out_last=0, grant=0, burst_err=0.
  - Internal: state=IDLE, rr_ptr=2 so A wins first, beat counter=0.
  - Reset asserted mid-burst discards the burst and the output register contents immediately.
- FSM states: IDLE, LOCKED.
- IDLE:
  - grant=0 and all *_ready=0.
  - At a clock edge with any valid=1: pick the first valid requester searching from rr_ptr+1 mod 3 (wrap 2->0).
  - Register that requester in grant, clear the counter, go to LOCKED.
- LOCKED:
  - Only the granted requester's ready may be 1: ready = grant bit && (!out_valid || out_ready).
  - On an accepted beat, register out_data=payload, out_last=last, out_sel=index, out_valid=1, and increment the counter.
  - An accepted beat with last=1, or the MAX_BURST-th accepted beat, ends the burst:
    - set rr_ptr=owner, clear grant, go to IDLE;
    - a new grant can be issued at the next edge.
  - Forced release (MAX_BURST-th beat with last=0): burst_err pulses for 1 cycle and out_last is forced to 1. The requester re-arbitrates for its remaining beats.
- Output register:
  - out_valid clears when out_ready=1 and no new beat is accepted in the same cycle.
  - Simultaneous accept-in and drain-out reloads the register with no bubble.
  - out_data, out_sel and out_last hold while out_valid=1 && out_ready=0.
- Latency and throughput:
  - Request to grant: 1 cycle.
  - Accepted beat to out_valid: 1 cycle.
  - Sustained 1 beat/cycle within a burst when out_ready=1.
  - One idle arbitration cycle between bursts.
- Valid deassertion mid-burst keeps the lock; the owner is not released until last or MAX_BURST.
- Non-granted requesters are never given ready=1, regardless of their valid.
- Counter width is clog2(MAX_BURST+1) and it never wraps. MAX_BURST=1 makes every beat a burst end.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: IDLE selection is fixed priority A>B>C. rr_ptr is neither used nor updated, and a continuously requesting A starves B and C.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then A single beat: a_valid=1, a_last=1, a_data=11, out_ready=1 -> grant=001 at cycle 1, out_data=11, out_sel=0, out_valid=1 at cycle 2, out_last=1.
- All three valid with one-beat bursts (data 11/22/33), out_ready=1 held -> output order A, B, C, A with data 11, 22, 33, 11; one idle cycle between grants.
- B 3-beat burst (22, 23, 24; last on 24) while A and C valid -> grant stays 010 for 3 accepted beats; A and C ready stay 0; next grant goes to C.
- Back-pressure: out_ready=0 during C burst -> c_ready=0 after first beat; out_data=33 stable; resumes 1 beat/cycle when out_ready=1.
- A never asserts last with MAX_BURST=16 -> after 16th accepted beat, burst_err=1 for one cycle, out_last=1, grant goes to B if b_valid=1.
- rst_n pulled low mid-burst of A (beat 2 of 4) -> out_valid=0, grant=000 immediately; after release, A re-wins first arbitration.
